// File: rtl/pipelined_cla_adder_pkg.sv
// pipelined_cla_adder_pkg
//   Shared constants and elaboration-time helpers for the pipelined CLA adder.
//   SLICE_W      : width of one fast-carry slice (cla4_slice)
//   calc_stages  : pipeline depth for a given operand width and bits per stage
//   cfg_ok       : legality check for the WIDTH / STAGE_BITS pair
package pipelined_cla_adder_pkg;

    localparam int SLICE_W = 4;

    function automatic int calc_stages(input int width, input int stage_bits);
        return width / stage_bits;
    endfunction

    function automatic bit cfg_ok(input int width, input int stage_bits);
        return (stage_bits > 0) && (stage_bits % SLICE_W == 0) &&
               (width >= stage_bits) && (width % stage_bits == 0);
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// pipelined_cla_adder_if
//   Operand/result streaming bus of the pipelined CLA adder.
//   Operand side : in_valid, in_ready, a, b, cin, sub
//   Result side  : out_valid, out_ready, sum, cout (+ ovf, zero with CLA_FLAGS_EN)
//   master : producer of operands / consumer of results
//   slave  : the adder
//   Build option: CLA_FLAGS_EN adds the ovf/zero flag signals.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_FLAGS_EN
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/pipelined_cla_adder_cla4_slice.sv
// cla4_slice
//   Combinational 4-bit carry-lookahead slice.
//   a, b : 4-bit operands      ci : carry in
//   s    : 4-bit sum           co : carry out
//   gp   : group propagate     gg : group generate (for chaining slices)
module cla4_slice
    import pipelined_cla_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co,
    output logic               gp,
    output logic               gg
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    assign gp = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign co = gg | (gp & ci);

    assign s = p ^ c;
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   N-bit add/subtract unit, STAGE_BITS resolved per pipeline stage, carry
//   registered between stages, valid/ready handshake with back-pressure.
//   {cout,sum} = a + (b ^ {WIDTH{sub}}) + (cin ^ sub); latency STAGES clocks.
//   Ports: clk, rst_n (async, active-low), io (pipelined_cla_adder_if.slave).
//   Build option: CLA_FLAGS_EN adds registered ovf (signed overflow) and
//   zero (sum == 0) outputs.
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int STAGE_BITS = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    pipelined_cla_adder_if.slave  io
);
    localparam int STAGES = calc_stages(WIDTH, STAGE_BITS);
    localparam int SLICES = STAGE_BITS / SLICE_W;

    if (!cfg_ok(WIDTH, STAGE_BITS)) begin : g_cfg_check
        $error("pipelined_cla_adder: WIDTH must be a multiple of STAGE_BITS, STAGE_BITS a multiple of 4");
    end

    // rdy[k]: stage k may load this cycle; the chain is purely combinational.
    logic [STAGES:0]  rdy;
    logic [WIDTH-1:0] eb0;

    assign eb0         = io.b ^ {WIDTH{io.sub}};
    assign rdy[STAGES] = io.out_ready;
    assign io.in_ready = rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * STAGE_BITS;

        logic             v_i;
        logic [WIDTH-1:0] a_i;
        logic [WIDTH-1:0] eb_i;
        logic [WIDTH-1:0] s_i;
        logic             c_i;
        logic [SLICES:0]  sc;
        logic [SLICES-1:0] sp;
        logic [SLICES-1:0] sg;
        logic [SLICES-1:0] sco;
        logic [STAGE_BITS-1:0] s_bits;
        logic [WIDTH-1:0] s_n;
        logic             vld_p;
        logic [WIDTH-1:0] s_p;
        logic             c_p;
        logic             unused_stage;

        // ---- stage k input: ports for stage 0, previous stage registers otherwise
        if (k == 0) begin : g_src
            assign v_i  = io.in_valid;
            assign a_i  = io.a;
            assign eb_i = eb0;
            assign c_i  = io.cin ^ io.sub;
            assign s_i  = '0;
        end else begin : g_src
            assign v_i  = g_stg[k-1].vld_p;
            assign a_i  = g_stg[k-1].g_fwd.a_p;
            assign eb_i = g_stg[k-1].g_fwd.eb_p;
            assign c_i  = g_stg[k-1].c_p;
            assign s_i  = g_stg[k-1].s_p;
        end

        // Slices inside one stage ripple through their group P/G terms.
        assign sc[0] = c_i;
        for (genvar j = 0; j < SLICES; j++) begin : g_slice
            cla4_slice u_slice (
                .a  (a_i[LO + j*SLICE_W +: SLICE_W]),
                .b  (eb_i[LO + j*SLICE_W +: SLICE_W]),
                .ci (sc[j]),
                .s  (s_bits[j*SLICE_W +: SLICE_W]),
                .co (sco[j]),
                .gp (sp[j]),
                .gg (sg[j])
            );
            assign sc[j+1] = sg[j] | (sp[j] & sc[j]);
        end

        always_comb begin
            s_n = s_i;
            s_n[LO +: STAGE_BITS] = s_bits;
        end

        assign rdy[k] = !vld_p | rdy[k+1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p <= 1'b0;
            end else if (rdy[k]) begin
                vld_p <= v_i;
            end
        end

        // ---- stage k register: intermediate stages carry operands forward
        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] a_p;
            logic [WIDTH-1:0] eb_p;

            always_ff @(posedge clk) begin
                if (rdy[k] && v_i) begin
                    a_p  <= a_i;
                    eb_p <= eb_i;
                    s_p  <= s_n;
                    c_p  <= sc[SLICES];
                end
            end

            assign unused_stage = ^sco;
        end else begin : g_last
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_p <= '0;
                    c_p <= 1'b0;
                end else if (rdy[k] && v_i) begin
                    s_p <= s_n;
                    c_p <= sc[SLICES];
                end
            end

`ifdef CLA_FLAGS_EN
            logic ovf_p;
            logic zero_p;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_p  <= 1'b0;
                    zero_p <= 1'b0;
                end else if (rdy[k] && v_i) begin
                    ovf_p  <= (a_i[WIDTH-1] == eb_i[WIDTH-1]) & (s_n[WIDTH-1] != a_i[WIDTH-1]);
                    zero_p <= ~|s_n;
                end
            end

            assign io.ovf  = ovf_p;
            assign io.zero = zero_p;
`endif
            // Operand bits below this stage were consumed upstream.
            if (k > 0) begin : g_sink
                assign unused_stage = ^{sco, a_i[LO-1:0], eb_i[LO-1:0]};
            end else begin : g_sink
                assign unused_stage = ^sco;
            end

            assign io.out_valid = vld_p;
            assign io.sum       = s_p;
            assign io.cout      = c_p;
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder
//   Directed bench for pipelined_cla_adder (WIDTH=16, STAGE_BITS=4).
//   With CLA_FLAGS_EN defined the ovf/zero outputs are checked as well.
module tb_pipelined_cla_adder;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(W)) bus ();

    pipelined_cla_adder #(.WIDTH(W), .STAGE_BITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Streaming table: a, b, cin, sub and hand-computed sum/cout.
    logic [15:0] sa  [0:7] = '{16'h0001, 16'h00FF, 16'h0F0F, 16'hFFFF, 16'h1000, 16'h0000, 16'hABCD, 16'h8000};
    logic [15:0] sb  [0:7] = '{16'h0002, 16'h0001, 16'hF0F0, 16'hFFFF, 16'h0001, 16'h0001, 16'h1111, 16'h8000};
    bit          sci [0:7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bit          ssb [0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] se  [0:7] = '{16'h0003, 16'h0100, 16'hFFFF, 16'hFFFF, 16'h0FFF, 16'hFFFF, 16'hBCDF, 16'h0000};
    bit          sco [0:7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
    endtask

    // Called at a negedge with an empty pipe; returns at the negedge where the
    // result is presented (4 clocks after accept), result not yet popped.
    task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub,
                           input logic [15:0] es, input logic ec);
        bus.out_ready = 1'b1;
        set_beat(a, b, cin, sub);
        #1 chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        chk({tag, "_popped"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  tx;
        int  rx;
        int  occ;
        int  cyc;
        bit  saw_full;
        bit  acc;
        bit  pop;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
`ifdef CLA_FLAGS_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Basic add, full carry ripple, subtract with and without borrow-in
        run_one("add_5555", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
`ifdef CLA_FLAGS_EN
        chk("add_5555_ovf", 32'(bus.ovf), 32'd0);
        chk("add_5555_zero", 32'(bus.zero), 32'd0);
`endif
        drain("add_5555");

        run_one("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
`ifdef CLA_FLAGS_EN
        chk("wrap_ovf", 32'(bus.ovf), 32'd0);
        chk("wrap_zero", 32'(bus.zero), 32'd1);
`endif
        drain("wrap");

        run_one("sub_c0", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        drain("sub_c0");
        run_one("sub_c1", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0);
        drain("sub_c1");

        run_one("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0);
`ifdef CLA_FLAGS_EN
        chk("ovf_add_ovf", 32'(bus.ovf), 32'd1);
        chk("ovf_add_zero", 32'(bus.zero), 32'd0);
`endif
        drain("ovf_add");

        run_one("sub_eq", 16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1);
`ifdef CLA_FLAGS_EN
        chk("sub_eq_ovf", 32'(bus.ovf), 32'd0);
        chk("sub_eq_zero", 32'(bus.zero), 32'd1);
`endif
        drain("sub_eq");

        // Streaming with a 5-clock output stall; in_ready = out_ready | pipe not full
        tx = 0; rx = 0; occ = 0; cyc = 0; saw_full = 1'b0;
        while (rx < 8 && cyc < 60) begin
            bus.out_ready = !(cyc >= 2 && cyc < 7);
            if (tx < 8) set_beat(sa[tx], sb[tx], sci[tx], ssb[tx]);
            else        bus.in_valid = 1'b0;
            #1;
            chk("stream_in_ready", 32'(bus.in_ready), 32'(bus.out_ready || (occ < 4)));
            if (!bus.in_ready && tx < 8) saw_full = 1'b1;
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                if (rx < 8) begin
                    chk("stream_sum", 32'(bus.sum), 32'(se[rx]));
                    chk("stream_cout", 32'(bus.cout), 32'(sco[rx]));
                end else begin
                    chk("stream_extra_result", 32'(rx), 32'd7);
                end
            end
            pop = bus.out_valid && bus.out_ready;
            if (acc) tx++;
            if (pop) rx++;
            occ = occ + int'(acc) - int'(pop);
            cyc++;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("stream_results", 32'(rx), 32'd8);
        chk("stream_accepts", 32'(tx), 32'd8);
        chk("stream_saw_full", 32'(saw_full), 32'd1);
        @(negedge clk);
        chk("stream_drained", 32'(bus.out_valid), 32'd0);

        // Reset with three beats in flight
        bus.out_ready = 1'b0;
        set_beat(16'h0100, 16'h0200, 1'b0, 1'b0);
        @(negedge clk);
        set_beat(16'h0011, 16'h0022, 1'b0, 1'b0);
        @(negedge clk);
        set_beat(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flight_out_valid", 32'(bus.out_valid), 32'd1);
        chk("flight_sum", 32'(bus.sum), 32'h0300);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_sum", 32'(bus.sum), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
        end
        run_one("post_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0);
`ifdef CLA_FLAGS_EN
        chk("post_rst_ovf", 32'(bus.ovf), 32'd0);
        chk("post_rst_zero", 32'(bus.zero), 32'd0);
`endif
        drain("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
